// File: rtl/instruction_mem_ctrl.sv
// Instruction memory for the fetch stage.
// A valid/ready request channel reads a synchronous word array. A small
// response FIFO absorbs consumer backpressure. A byte-masked load port and a
// flush for redirects are also provided.
module instruction_mem_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DEPTH_WORDS    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    RSP_FIFO_DEPTH = 2,
    parameter string                 INIT_FILE      = ""
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic                           rsp_err_o,
    input  logic                           flush_i,
    input  logic                           load_en_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0]          load_data_i,
    input  logic [DATA_WIDTH/8-1:0]        load_wmask_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(RSP_FIFO_DEPTH);

    // Word array and its registered read port.
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Stage 1: the request whose array read is in flight.
    logic s1_valid_q, s1_valid_d;
    logic s1_err_q, s1_err_d;

    // Response FIFO.
    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_FIFO_DEPTH];
    logic                  fifo_err_q  [RSP_FIFO_DEPTH];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_err;
    logic [CNT_W:0]        occupancy;
    logic                  accept;
    logic                  fifo_empty;
    logic                  rsp_fire;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] s1_data;

    // Address decode. The subtraction wraps, so addresses below the base
    // become huge offsets and are caught by the range check.
    assign off     = req_addr_i - BASE_ADDR;
    assign req_idx = off[IDX_W+1:2];
    assign req_err = (off[1:0] != 2'b00) || (off[ADDR_WIDTH-1:IDX_W+2] != '0);

    // Stage 1 and the FIFO together hold every response that has not been
    // consumed. Capping their sum means a response is never dropped.
    assign occupancy   = {1'b0, cnt_q} + (CNT_W + 1)'(s1_valid_q);
    assign req_ready_o = rst_n & ~flush_i & ~load_en_i & (occupancy < OCC_MAX);
    assign accept      = req_valid_i & req_ready_o;

    assign fifo_empty = (cnt_q == '0);
    assign s1_data    = s1_err_q ? '0 : rd_data_q;

    // Output select. When the FIFO is empty, stage 1 bypasses to the
    // outputs. Otherwise the outputs show the FIFO head.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        if (fifo_empty) begin
            rsp_valid_o = s1_valid_q;
            rsp_data_o  = s1_valid_q ? s1_data : '0;
            rsp_err_o   = s1_valid_q & s1_err_q;
        end else begin
            rsp_valid_o = 1'b1;
            rsp_data_o  = fifo_data_q[rptr_q];
            rsp_err_o   = fifo_err_q[rptr_q];
        end
    end

    assign rsp_fire = rsp_valid_o & rsp_ready_i;
    // A stage-1 response goes into the FIFO unless the bypass consumed it.
    // A response shown during a flush is discarded, not consumed.
    assign push = s1_valid_q & ~(fifo_empty & rsp_fire) & ~flush_i;
    assign pop  = ~fifo_empty & rsp_fire & ~flush_i;

    // Next-state logic for stage 1 and the FIFO bookkeeping.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = accept & req_err;
        cnt_d      = cnt_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        if (flush_i) begin
            cnt_d  = '0;
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            cnt_q      <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            cnt_q      <= cnt_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    // Array write (byte-masked) and registered read. Loads and fetches never
    // share a cycle, so a read already in stage 1 keeps the old word.
    always_ff @(posedge clk) begin
        if (load_en_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (load_wmask_i[b]) begin
                    mem[load_addr_i][b*8 +: 8] <= load_data_i[b*8 +: 8];
                end
            end
        end
        if (accept && !req_err) begin
            rd_data_q <= mem[req_idx];
        end
    end

    // FIFO storage. It needs no reset because the count qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= s1_data;
            fifo_err_q[wptr_q]  <= s1_err_q;
        end
    end

endmodule

// File: tb/tb_instruction_mem_ctrl.sv
// Self-checking bench for instruction_mem_ctrl (default parameters).
// The reference model keeps a word array and a queue of outstanding
// responses. Inputs are driven on the falling edge, and outputs are compared
// 1 ns later.
module tb_instruction_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        flush_i;
    logic        load_en_i;
    logic [7:0]  load_addr_i;
    logic [31:0] load_data_i;
    logic [3:0]  load_wmask_i;

    instruction_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .flush_i      (flush_i),
        .load_en_i    (load_en_i),
        .load_addr_i  (load_addr_i),
        .load_data_i  (load_data_i),
        .load_wmask_i (load_wmask_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        exp_err;
    } vec_t;

    logic [31:0] mdl_mem [256];
    rsp_t        q [$];

    int checks = 0;
    int errors = 0;

    // Values sampled in the most recent step, and what the model did then.
    logic        s_valid, s_ready, s_err;
    logic [31:0] s_data;
    logic        last_acc, last_cons;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 256);
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic rr,
                        input logic fl, input logic le, input logic [7:0] la,
                        input logic [31:0] ld, input logic [3:0] lm);
        logic exp_ready, exp_valid, acc, cons;
        rsp_t e;
        @(negedge clk);
        req_valid_i  = v;
        req_addr_i   = a;
        rsp_ready_i  = rr;
        flush_i      = fl;
        load_en_i    = le;
        load_addr_i  = la;
        load_data_i  = ld;
        load_wmask_i = lm;
        #1;
        s_valid = rsp_valid_o;
        s_ready = req_ready_o;
        s_data  = rsp_data_o;
        s_err   = rsp_err_o;
        exp_ready = !fl && !le && (q.size() < 2);
        exp_valid = (q.size() != 0);
        check("req_ready", {31'b0, req_ready_o}, {31'b0, exp_ready});
        check("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_valid});
        if (exp_valid && rsp_valid_o) begin
            check("rsp_data", rsp_data_o, q[0].data);
            check("rsp_err", {31'b0, rsp_err_o}, {31'b0, q[0].err});
        end
        acc  = v && exp_ready;
        cons = exp_valid && rr && !fl;
        last_acc  = acc;
        last_cons = cons;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (cons) begin
                e = q.pop_front();
                $display("rsp addr=%h data=%h err=%0d", e.addr, e.data, e.err);
            end
            if (acc) begin
                e.addr = a;
                e.err  = addr_err(a);
                e.data = e.err ? 32'h0 : mdl_mem[a / 4];
                q.push_back(e);
            end
        end
        if (le) begin
            for (int b = 0; b < 4; b++) begin
                if (lm[b]) mdl_mem[la][b*8 +: 8] = ld[b*8 +: 8];
            end
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, rr, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        step(1'b1, a, rr, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic load(input logic [7:0] la, input logic [31:0] ld, input logic [3:0] lm);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, la, ld, lm);
    endtask

    vec_t vecs [8];
    int   cnt;

    initial begin
        vecs[0] = '{32'h0000_0002, 1'b1};
        vecs[1] = '{32'h0000_0400, 1'b1};
        vecs[2] = '{32'h0000_03FC, 1'b0};
        vecs[3] = '{32'h0000_0001, 1'b1};
        vecs[4] = '{32'hFFFF_FFFC, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b0};
        vecs[6] = '{32'h0000_03FF, 1'b1};
        vecs[7] = '{32'h0000_0100, 1'b0};

        rst_n = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 32'h0; rsp_ready_i = 1'b1;
        flush_i = 1'b0; load_en_i = 1'b0; load_addr_i = 8'h0;
        load_data_i = 32'h0; load_wmask_i = 4'h0;
        #12;
        check("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("reset_rsp_data", rsp_data_o, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err_o}, 32'h0);
        check("reset_req_ready", {31'b0, req_ready_o}, 32'h0);
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_n = 1'b1;

        // Preload the array. Word 0 holds the first boot instruction.
        for (int i = 0; i < 256; i++) begin
            load(8'(i), (i == 0) ? 32'h0050_0093 : $urandom, 4'hF);
        end
        check("load_blocks_ready", {31'b0, s_ready}, 32'h0);

        // Reset with two responses buffered.
        fetch(32'h10, 1'b0);
        fetch(32'h14, 1'b0);
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("midreset_req_ready", {31'b0, req_ready_o}, 32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        check("post_reset_no_rsp", {31'b0, s_valid}, 32'h0);
        fetch(32'h0, 1'b1);
        idle(1'b1);
        check("init_word0", s_data, 32'h0050_0093);

        // Streaming: four back-to-back requests at latency 1.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) fetch(32'(i * 4), 1'b1);
            else       idle(1'b1);
            if (i > 0) begin
                check("stream_valid", {31'b0, s_valid}, 32'h1);
                check("stream_data", s_data, mdl_mem[i - 1]);
            end
        end

        // Backpressure: only two requests are accepted, then two drain.
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'h40 + 32'(i * 4), 1'b0);
            if (last_acc) cnt++;
        end
        check("bp_accepts", 32'(cnt), 32'd2);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (last_cons && s_valid) cnt++;
        end
        check("bp_drained", 32'(cnt), 32'd2);

        // Address error table.
        foreach (vecs[i]) begin
            fetch(vecs[i].addr, 1'b1);
            idle(1'b1);
            check("err_tbl", {31'b0, s_err}, {31'b0, vecs[i].exp_err});
            if (vecs[i].exp_err) check("err_tbl_data", s_data, 32'h0);
        end

        // Byte-masked load.
        load(8'd5, 32'hDEAD_BEEF, 4'hF);
        check("load_ready_low", {31'b0, s_ready}, 32'h0);
        load(8'd5, 32'h0000_0011, 4'h1);
        fetch(32'h14, 1'b1);
        idle(1'b1);
        check("load_masked", s_data, 32'hDEAD_BE11);

        // Read-first: a load after the fetch must not change its response.
        fetch(32'h18, 1'b0);
        load(8'd6, 32'h1234_5678, 4'hF);
        idle(1'b1);
        idle(1'b1);

        // Flush with two buffered responses.
        fetch(32'h20, 1'b0);
        fetch(32'h24, 1'b0);
        step(1'b1, 32'h28, 1'b0, 1'b1, 1'b0, 8'h0, 32'h0, 4'h0);
        idle(1'b1);
        check("flush_clears", {31'b0, s_valid}, 32'h0);
        fetch(32'h8, 1'b1);
        idle(1'b1);
        check("flush_refetch", s_data, mdl_mem[2]);
        idle(1'b1);
        check("flush_single", {31'b0, s_valid}, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic        fl, le;
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
            fl = ($urandom_range(0, 29) == 0);
            le = !fl && ($urandom_range(0, 19) == 0);
            step(1'($urandom), a, ($urandom_range(0, 3) != 0), fl, le,
                 8'($urandom), $urandom, 4'($urandom));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
